// File: rtl/flex_counter_pkg.sv
// Shared types and constants for the flex_counter scheduler.
package flex_counter_pkg;

  localparam int CNT_BITS_DEFAULT = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        idx    = IDX_W'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flex_counter_sched.sv
// Round-robin scheduler sharing one flex_counter among NUM_REQ interval requesters.
//   state | meaning
//   IDLE  | waiting for any request, arbitrate round-robin
//   LOAD  | counter cleared, rollover value = latched length
//   RUN   | counter enabled by tick, wait for rollover or abort
//   DONE  | one-cycle done pulse to owner, counter cleared
module flex_counter_sched
  import flex_counter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int NUM_CNT_BITS = CNT_BITS_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tick,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*NUM_CNT_BITS-1:0] req_len,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic                            cnt_clear,
  output logic                            cnt_enable,
  output logic [NUM_CNT_BITS-1:0]         cnt_rollover_val,
  input  logic                            cnt_rollover_flag
);

  localparam int IDX_W = $clog2(NUM_REQ);

  sched_state_t             state;
  logic [IDX_W-1:0]         rr_ptr;
  logic [IDX_W-1:0]         owner_q;
  logic [NUM_CNT_BITS-1:0]  len_q;
  logic [NUM_REQ-1:0]       arb_gnt;
  logic [IDX_W-1:0]         arb_idx;
  logic                     arb_valid;
  logic [NUM_CNT_BITS-1:0]  win_len;
  logic                     abort;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign win_len = req_len[arb_idx*NUM_CNT_BITS +: NUM_CNT_BITS];

  // Rollover wins over a simultaneous request drop.
  assign abort = (state == RUN) && !cnt_rollover_flag && !req[owner_q];

  // The counter's own reset handles the reset cycle, so nothing is driven then.
  assign cnt_clear        = !rst && ((state == LOAD) || (state == DONE) || abort);
  assign cnt_enable       = !rst && (state == RUN) && !abort && tick;
  assign cnt_rollover_val = len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner_q <= '0;
      len_q   <= '0;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant   <= arb_gnt;
            owner_q <= arb_idx;
            len_q   <= win_len;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (len_q == '0) begin
            done  <= grant;
            state <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt_rollover_flag) begin
            done  <= grant;
            state <= DONE;
          end else if (!req[owner_q]) begin
            grant  <= '0;
            busy   <= 1'b0;
            rr_ptr <= wrap_inc(owner_q);
            state  <= IDLE;
          end
        end
        DONE: begin
          grant  <= '0;
          busy   <= 1'b0;
          rr_ptr <= wrap_inc(owner_q);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flex_counter_sched.sv
// Scoreboard bench for flex_counter_sched with a behavioural flex_counter attached.
module tb_flex_counter_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  req = '0;
  logic [8:0]  lens [4];
  logic [35:0] req_len;
  logic [3:0]  grant, done;
  logic        busy, cnt_clear, cnt_enable;
  logic [8:0]  cnt_rollover_val;
  logic        cnt_rollover_flag;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    bit         is_done;
    logic [3:0] val;
    int         at;
  } ev_t;
  ev_t exp_q[$];

  assign req_len = {lens[3], lens[2], lens[1], lens[0]};

  flex_counter_sched #(.NUM_REQ(4), .NUM_CNT_BITS(9)) dut (
    .clk               (clk),
    .rst               (rst),
    .tick              (tick),
    .req               (req),
    .req_len           (req_len),
    .grant             (grant),
    .done              (done),
    .busy              (busy),
    .cnt_clear         (cnt_clear),
    .cnt_enable        (cnt_enable),
    .cnt_rollover_val  (cnt_rollover_val),
    .cnt_rollover_flag (cnt_rollover_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural flex_counter: flag follows the registered count matching rollover_val
  logic [8:0] cnt;
  logic [8:0] cnt_nxt;
  always @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      cnt_rollover_flag <= 1'b0;
    end else if (cnt_clear) begin
      cnt <= '0;
      cnt_rollover_flag <= 1'b0;
    end else if (cnt_enable) begin
      cnt_nxt = (cnt == cnt_rollover_val) ? 9'd1 : cnt + 9'd1;
      cnt <= cnt_nxt;
      cnt_rollover_flag <= (cnt_nxt == cnt_rollover_val);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  task automatic push(input bit is_done, input logic [3:0] val, input int at);
    ev_t e;
    e.is_done = is_done;
    e.val = val;
    e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor: every new grant and every done pulse must match the next expected event
  logic [3:0] prev_grant = '0;
  task automatic observe(input bit is_done, input logic [3:0] val);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_%s @cyc %0d: got %b expected no event",
               is_done ? "done" : "grant", cyc, val);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done != is_done || e.val !== val || e.at != cyc) begin
        fails++;
        $display("FAIL event: got %s=%b @cyc %0d expected %s=%b @cyc %0d",
                 is_done ? "done" : "grant", val, cyc,
                 e.is_done ? "done" : "grant", e.val, e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (grant != prev_grant && grant != '0) observe(1'b0, grant);
    if (done != '0) observe(1'b1, done);
    prev_grant = grant;
  end

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_clear", 32'(cnt_clear), 32'h0);
    chk("rst_enable", 32'(cnt_enable), 32'h0);
    chk("rst_rollval", 32'(cnt_rollover_val), 32'h0);
  endtask

  int e;

  initial begin
    for (int i = 0; i < 4; i++) lens[i] = '0;
    @(posedge clk);
    #1;

    // single request, len 3, tick always on
    do_reset();
    e = cyc;
    lens[0] = 9'd3; tick = 1'b1; req = 4'b0001;
    push(1'b0, 4'b0001, e + 1);
    push(1'b1, 4'b0001, e + 6);
    wait_cyc(e + 1);
    chk("single_load_clear", 32'(cnt_clear), 32'h1);
    chk("single_load_busy", 32'(busy), 32'h1);
    chk("single_rollval", 32'(cnt_rollover_val), 32'h3);
    wait_cyc(e + 6);
    req = '0;
    wait_cyc(e + 7);
    chk("single_idle_busy", 32'(busy), 32'h0);
    chk("single_idle_grant", 32'(grant), 32'h0);

    // fairness: all four requesting, len 2
    do_reset();
    e = cyc;
    for (int i = 0; i < 4; i++) lens[i] = 9'd2;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 4'(1 << (i % 4)), e + 1 + 6 * i);
      push(1'b1, 4'(1 << (i % 4)), e + 5 + 6 * i);
    end
    wait_cyc(e + 29);
    req = '0;
    wait_cyc(e + 32);
    chk("fair_idle_busy", 32'(busy), 32'h0);

    // tick gating: len 5, tick every third cycle
    do_reset();
    e = cyc;
    lens[0] = 9'd5; req = 4'b0001;
    push(1'b0, 4'b0001, e + 1);
    push(1'b1, 4'b0001, e + 17);
    for (int c = 0; c <= 18; c++) begin
      wait_cyc(e + c);
      tick = ((c % 3) == 0);
      if (c == 17) req = '0;
      #1;
      chk("gate_enable", 32'(cnt_enable), 32'(tick && c >= 2 && c <= 16));
    end
    tick = 1'b1;

    // length 0 on requester 2, then pointer advances to 3 then wraps to 0
    do_reset();
    e = cyc;
    lens[2] = 9'd0; lens[3] = 9'd1; lens[0] = 9'd1; req = 4'b0100;
    push(1'b0, 4'b0100, e + 1);
    push(1'b1, 4'b0100, e + 2);
    push(1'b0, 4'b1000, e + 4);
    push(1'b1, 4'b1000, e + 7);
    push(1'b0, 4'b0001, e + 9);
    push(1'b1, 4'b0001, e + 12);
    for (int c = 0; c <= 3; c++) begin
      wait_cyc(e + c);
      if (c == 2) req = 4'b1001;
      #1;
      chk("len0_enable", 32'(cnt_enable), 32'h0);
      if (c == 1 || c == 2) chk("len0_clear", 32'(cnt_clear), 32'h1);
    end
    wait_cyc(e + 7);
    req = 4'b0001;
    wait_cyc(e + 12);
    req = '0;
    wait_cyc(e + 14);
    chk("len0_idle_busy", 32'(busy), 32'h0);

    // abort: requester 1 drops mid-run, pending requester 2 wins next
    do_reset();
    e = cyc;
    lens[1] = 9'd9; lens[2] = 9'd2; req = 4'b0110;
    push(1'b0, 4'b0010, e + 1);
    push(1'b0, 4'b0100, e + 7);
    push(1'b1, 4'b0100, e + 11);
    wait_cyc(e + 5);
    req = 4'b0100;
    #1;
    chk("abort_clear", 32'(cnt_clear), 32'h1);
    wait_cyc(e + 6);
    chk("abort_grant", 32'(grant), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    wait_cyc(e + 11);
    req = '0;

    // reset mid-run during a len-9 count
    do_reset();
    e = cyc;
    lens[0] = 9'd9; lens[1] = 9'd2; req = 4'b0011;
    push(1'b0, 4'b0001, e + 1);
    push(1'b0, 4'b0001, e + 7);
    push(1'b1, 4'b0001, e + 18);
    push(1'b0, 4'b0010, e + 20);
    push(1'b1, 4'b0010, e + 24);
    wait_cyc(e + 5);
    rst = 1'b1;
    wait_cyc(e + 6);
    rst = 1'b0;
    #1;
    chk("mrst_grant", 32'(grant), 32'h0);
    chk("mrst_done", 32'(done), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_clear", 32'(cnt_clear), 32'h0);
    chk("mrst_enable", 32'(cnt_enable), 32'h0);
    chk("mrst_rollval", 32'(cnt_rollover_val), 32'h0);
    wait_cyc(e + 18);
    req = 4'b0010;
    wait_cyc(e + 24);
    req = '0;

    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    wait_cyc(cyc + 3);
    chk("events_outstanding", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/flex_counter_sched.md
# flex_counter_sched

Round-robin scheduler that shares one `flex_counter` instance (NUM_CNT_BITS-wide) among NUM_REQ requesters that each need a timed interval.
- Per grant, the scheduler:
  - latches the winner's interval length;
  - clears the counter;
  - gates the counter's enable with an external tick;
  - watches `rollover_flag`;
  - returns a one-cycle `done` pulse to the winner.
- It sits between the requesting blocks and the `flex_counter` and drives all of the counter's control inputs.

## Interface
Parameters:
- NUM_REQ, default 4: number of requesters. Must be at least 2.
- NUM_CNT_BITS, default 9: counter width. Must match the attached `flex_counter`.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: reset, **synchronous, active-high**.
- tick, input, 1: count strobe, forwarded to the counter only while in RUN.
- req, input, NUM_REQ: level request per requester. Held until `done` or abort.
- req_len, input, NUM_REQ*NUM_CNT_BITS: interval length per requester. Slice i is `req_len[i*NUM_CNT_BITS +: NUM_CNT_BITS]`.
- grant, output, NUM_REQ: one-hot (or zero) current owner. Registered.
- done, output, NUM_REQ: one-cycle completion pulse to the owner. Registered.
- busy, output, 1: high in any state except IDLE.
- cnt_clear, output, 1: drives `flex_counter.clear`.
- cnt_enable, output, 1: drives `flex_counter.count_enable`.
- cnt_rollover_val, output, NUM_CNT_BITS: drives `flex_counter.rollover_val`.
- cnt_rollover_flag, input, 1: from `flex_counter.rollover_flag`.

## Operation
FSM states: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - If any `req` is high, pick the winner round-robin: the first set bit at or after `rr_ptr`, wrapping.
  - Register `grant`, latch the winner's `req_len` into `len_q`, then go to LOAD.
- **LOAD** (exactly 1 cycle)
  - `cnt_clear`=1, `cnt_enable`=0, `cnt_rollover_val`=`len_q`.
  - If `len_q`==0, go to DONE without counting, since the counter would never roll over. Otherwise go to RUN.
- **RUN**
  - `cnt_enable` = `tick`, `cnt_clear`=0.
  - On the first cycle with `cnt_rollover_flag`=1, go to DONE.
  - If the owner's `req` drops, abort:
    - `cnt_clear`=1 that cycle, no `done` pulse;
    - set `rr_ptr` = owner+1 mod NUM_REQ;
    - clear `grant` and go to IDLE.
- **DONE** (exactly 1 cycle)
  - `done[owner]`=1 and `cnt_clear`=1.
  - `grant` is cleared at the end of the cycle; `rr_ptr` = owner+1 mod NUM_REQ; go to IDLE.
- **Requests and length**
  - `req` bits for non-owners are ignored while `busy`.
  - `req_len` changes after LOAD have no effect.
- `cnt_rollover_val` holds `len_q` in every state. Its value after reset is 0.
- An abort and rollover in the same RUN cycle count as rollover: DONE with a `done` pulse.

## Timing
- **Reset** (`rst`=1 at an edge): after the edge, state=IDLE, `rr_ptr`=0, `len_q`=0, and `grant`, `done`, `busy`, `cnt_clear`, `cnt_enable`, `cnt_rollover_val` are all 0.
  - Reset mid-RUN drops the grant with no `done` pulse.
  - The counter is not cleared by this block in the reset cycle. The counter's own reset covers that.
- **Grant latency**: `req` seen in IDLE at edge k gives `grant` high from k+1 (LOAD); RUN starts at k+2.
- **Counting**: the counter counts `tick` pulses during RUN. `rollover_flag` rises at the edge where count reaches `len_q`, so RUN ends at the next edge. `done` is high exactly one cycle, the cycle after the flag is seen.
- **Back-to-back**: after DONE, IDLE can grant again at the next edge. Minimum request-to-request spacing is 4 cycles plus the count.
- **Output regs**: `grant`, `done`, `busy` are registered. `cnt_clear`, `cnt_enable` are decoded from the registered state plus `tick`, and may be combinational.
- **Length 0**: IDLE→LOAD→DONE, so `done` appears 2 cycles after the grant edge.

## Structure
- Shared package `flex_counter_pkg` holds:
  - the state enum `sched_state_t` (IDLE, LOAD, RUN, DONE);
  - the default width constant `CNT_BITS_DEFAULT` = 9.
- One sub-module, `rr_arbiter`: combinational round-robin pick. Inputs are `req` and `rr_ptr`; outputs are a one-hot winner, an index, and a valid flag. Parameterised by NUM_REQ.
- The `flex_counter` itself is instantiated by the parent, not inside this block. The test bench instantiates both.

## Test plan
- **Single request**: reset, then `req`=4'b0001 with len 3 and `tick` always 1 → `grant`=0001 from cycle 1; `done[0]` pulses 1 cycle after the rollover flag; `busy` is low after DONE.
- **Fairness**: `req`=4'b1111 held, all len 2 → grants in order 0,1,2,3,0; each `done[i]` pulses once per grant.
- **Tick gating**: len 5, `tick` every 3rd cycle → `cnt_enable` only mirrors `tick` in RUN; `done` follows the 5th tick plus 1 cycle.
- **Length 0**: requester 2 with len 0 → no `cnt_enable`; `done[2]` arrives 2 cycles after the grant edge; `rr_ptr` moves to 3.
- **Abort**: drop `req[1]` mid-RUN → `cnt_clear`=1 that cycle, no `done[1]`, back to IDLE; a pending `req[2]` is granted next.
- **Reset mid-RUN**: assert `rst` for 1 cycle during a len-9 count → all outputs are 0 the next cycle; `rr_ptr`=0, so requester 0 wins if it is requesting.
